seg_595_rx: RTL and testbench

Receiving end of the 74HC595 serial display link: samples the `ds`/`shcp`/`stcp`/`oe` pins driven by the 595 controller on the system clock and reconstructs the 6-bit digit select and 8-bit segment word. It behaves as a cycle-accurate functional model of the cascaded 595 pair on the display board, with framing checks. It serves as the in-fabric monitor and verification partner for the static and dynamic segment designs.

---
 rtl/seg_595_rx.sv | 149 ++++++++++++++
 tb/tb_seg_595_rx.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/seg_595_rx.sv
// Receive-side model of the cascaded 74HC595 pair: synchronizes ds/shcp/stcp/oe and rebuilds
// the 6-bit digit select and 8-bit segment word with framing checks. Optional SEG595_RX_FILT_EN.
module seg_595_rx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 3
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       ds,
  input  logic       shcp,
  input  logic       stcp,
  input  logic       oe,
  output logic [5:0] sel,
  output logic [7:0] seg,
  output logic       disp_en,
  output logic       frame_vld,
  output logic       frame_err
);

  // Pin vector order: {oe, stcp, shcp, ds}; oe idles high so its flops reset to 1.
  localparam logic [3:0] PinRst = 4'b1000;

  logic [3:0]                  pin_raw;
  logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
  logic [3:0]                  pin_s;
  logic [3:0]                  lvl;

  assign pin_raw = {oe, stcp, shcp, ds};

  always_comb begin
    sync_d = sync_q;
    for (int i = SYNC_STAGES - 1; i > 0; i--) begin
      sync_d[i] = sync_q[i-1];
    end
    sync_d[0] = pin_raw;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) sync_q <= {SYNC_STAGES{PinRst}};
    else         sync_q <= sync_d;
  end

  assign pin_s = sync_q[SYNC_STAGES-1];

`ifdef SEG595_RX_FILT_EN
  localparam int unsigned CntW = $clog2(FILT_LEN + 1);

  logic [3:0]           filt_q, filt_d;
  logic [3:0][CntW-1:0] fcnt_q, fcnt_d;

  // Level flips only after FILT_LEN consecutive samples disagreeing with it.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = fcnt_q;
    for (int i = 0; i < 4; i++) begin
      if (pin_s[i] != filt_q[i]) begin
        if (fcnt_q[i] == CntW'(FILT_LEN - 1)) begin
          filt_d[i] = pin_s[i];
          fcnt_d[i] = '0;
        end else begin
          fcnt_d[i] = fcnt_q[i] + 1'b1;
        end
      end else begin
        fcnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      filt_q <= PinRst;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = pin_s;
`endif

  logic [1:0]  hist_q;
  logic        shcp_rise, stcp_rise;
  logic [13:0] sr_q, sr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [5:0]  sel_q, sel_d;
  logic [7:0]  seg_q, seg_d;
  logic        vld_q, vld_d;
  logic        err_q, err_d;
  logic [13:0] sr_nxt;
  logic [3:0]  cnt_nxt;

  assign shcp_rise = lvl[1] & ~hist_q[0];
  assign stcp_rise = lvl[2] & ~hist_q[1];

  // Shift is resolved before latch so a coincident shcp/stcp rise latches the new bit.
  always_comb begin
    sr_nxt  = sr_q;
    cnt_nxt = cnt_q;
    if (shcp_rise) begin
      sr_nxt  = {sr_q[12:0], lvl[0]};
      cnt_nxt = (cnt_q == 4'd15) ? 4'd15 : cnt_q + 4'd1;
    end
    sr_d  = sr_nxt;
    cnt_d = cnt_nxt;
    sel_d = sel_q;
    seg_d = seg_q;
    vld_d = 1'b0;
    err_d = err_q;
    if (stcp_rise) begin
      for (int i = 0; i < 6; i++) begin
        sel_d[i] = sr_nxt[13-i];
      end
      seg_d = sr_nxt[7:0];
      vld_d = 1'b1;
      err_d = (cnt_nxt != 4'd14);
      cnt_d = '0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      hist_q <= '0;
      sr_q   <= '0;
      cnt_q  <= '0;
      sel_q  <= '0;
      seg_q  <= '0;
      vld_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      hist_q <= lvl[2:1];
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
      sel_q  <= sel_d;
      seg_q  <= seg_d;
      vld_q  <= vld_d;
      err_q  <= err_d;
    end
  end

  assign sel       = sel_q;
  assign seg       = seg_q;
  assign frame_vld = vld_q;
  assign frame_err = err_q;
  assign disp_en   = ~lvl[3];

endmodule

// File: tb/tb_seg_595_rx.sv
// Directed bench for seg_595_rx: drives the 595 pin protocol and checks decoded frames,
// framing errors, latency and reset behaviour. Glitch step runs only with SEG595_RX_FILT_EN.
module tb_seg_595_rx;

`ifdef SEG595_RX_FILT_EN
  localparam int Lat  = 6;
  localparam int DLat = 5;
  localparam int Hp   = 8;
`else
  localparam int Lat  = 3;
  localparam int DLat = 2;
  localparam int Hp   = 4;
`endif

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       ds, shcp, stcp, oe;
  logic [5:0] sel;
  logic [7:0] seg;
  logic       disp_en, frame_vld, frame_err;

  int checks   = 0;
  int failures = 0;

  seg_595_rx #(
    .SYNC_STAGES(2),
    .FILT_LEN   (3)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .ds       (ds),
    .shcp     (shcp),
    .stcp     (stcp),
    .oe       (oe),
    .sel      (sel),
    .seg      (seg),
    .disp_en  (disp_en),
    .frame_vld(frame_vld),
    .frame_err(frame_err)
  );

  always #10 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    ds = b;
    repeat (Hp) @(negedge sys_clk);
    shcp = 1'b1;
    repeat (Hp) @(negedge sys_clk);
    shcp = 1'b0;
  endtask

  // Sends bits w[n-1] down to w[0], MSB first on the wire.
  task automatic send_bits(input logic [15:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic do_latch(input string tag, input logic chk_data, input logic [5:0] es,
                          input logic [7:0] eg, input logic ee);
    int k;
    stcp = 1'b1;
    k = 0;
    while (k < 20) begin
      @(negedge sys_clk);
      k++;
      if (frame_vld === 1'b1) break;
    end
    chk({tag, "_lat"}, k, Lat);
    if (chk_data) begin
      chk({tag, "_sel"}, {26'd0, sel}, {26'd0, es});
      chk({tag, "_seg"}, {24'd0, seg}, {24'd0, eg});
    end
    chk({tag, "_err"}, {31'd0, frame_err}, {31'd0, ee});
    @(negedge sys_clk);
    chk({tag, "_vld_pulse"}, {31'd0, frame_vld}, 32'd0);
    repeat (Hp) @(negedge sys_clk);
    stcp = 1'b0;
    repeat (Hp) @(negedge sys_clk);
  endtask

  initial begin
    int k;
    sys_rst = 1'b1;
    ds = 1'b0; shcp = 1'b0; stcp = 1'b0; oe = 1'b1;
    repeat (5) @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("rst_sel", {26'd0, sel}, 32'd0);
    chk("rst_seg", {24'd0, seg}, 32'd0);
    chk("rst_vld", {31'd0, frame_vld}, 32'd0);
    chk("rst_err", {31'd0, frame_err}, 32'd0);
    chk("rst_disp_en", {31'd0, disp_en}, 32'd0);

    oe = 1'b0;
    k = 0;
    while (k < 20) begin
      @(negedge sys_clk);
      k++;
      if (disp_en === 1'b1) break;
    end
    chk("disp_en_lat", k, DLat);

    // sel=6'b111110, seg=8'hC0 -> wire word 14'h1FC0
    send_bits(16'h1FC0, 14);
    do_latch("frame_ok", 1'b1, 6'b111110, 8'hC0, 1'b0);

    // No bits since last latch: same contents, flagged as error
    do_latch("relatch", 1'b1, 6'b111110, 8'hC0, 1'b1);

    send_bits(16'h0AAA, 13);
    do_latch("short13", 1'b0, 6'd0, 8'd0, 1'b1);

    // Two extra leading bits fall off; last 14 encode sel=6'b101010, seg=8'h3C
    send_bits(16'hD53C, 16);
    do_latch("long16", 1'b1, 6'b101010, 8'h3C, 1'b1);

    // sel=6'b000001, seg=8'hA5 -> 14'h20A5; bit 14 shifted and latched in the same cycle
    send_bits(16'h20A5 >> 1, 13);
    ds = 1'b1;
    repeat (Hp) @(negedge sys_clk);
    shcp = 1'b1;
    do_latch("same_cycle", 1'b1, 6'b000001, 8'hA5, 1'b0);
    shcp = 1'b0;
    repeat (Hp) @(negedge sys_clk);

    send_bits(16'h007F, 7);
    sys_rst = 1'b1;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("midrst_sel", {26'd0, sel}, 32'd0);
    chk("midrst_seg", {24'd0, seg}, 32'd0);
    chk("midrst_err", {31'd0, frame_err}, 32'd0);
    // sel=6'b011111, seg=8'h3F -> 14'h3E3F
    send_bits(16'h3E3F, 14);
    do_latch("after_rst", 1'b1, 6'b011111, 8'h3F, 1'b0);

`ifdef SEG595_RX_FILT_EN
    send_bits(16'h20A5 >> 7, 7);
    shcp = 1'b1;
    @(negedge sys_clk);
    shcp = 1'b0;
    repeat (Hp) @(negedge sys_clk);
    send_bits(16'h0025, 7);
    do_latch("glitch", 1'b1, 6'b000001, 8'hA5, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
